// File: rtl/div_share_arb_if.sv
// ----------------------------------------------------------------------------
// div_share_arb_if
// Bundles every signal between the shared-divider arbiter and its environment
// (requesters, the pipelined divider and the response consumers).
//   en            grant enable from the system
//   req_valid     per-requester op valid
//   req_ready     one-hot grant back to requesters
//   req_dividend  packed dividends, requester i at [i*DW +: DW]
//   req_divisor   packed divisors, same packing
//   div_dividend  operand A to the divider
//   div_divisor   operand B to the divider (never 0)
//   div_quotient  quotient from the divider
//   rsp_valid     one-cycle response strobe
//   rsp_id        one-hot owner of the response
//   rsp_quot      response quotient (all-ones on divide-by-zero)
//   rsp_dz        response op had a zero divisor
//   busy          ops in flight or arbiter not idle
// slave  = arbiter view, master = environment view.
// ----------------------------------------------------------------------------
interface div_share_arb_if #(
   parameter int NREQ = 3,
   parameter int DW   = 18
) ();
   logic                 en;
   logic [NREQ-1:0]      req_valid;
   logic [NREQ-1:0]      req_ready;
   logic [NREQ*DW-1:0]   req_dividend;
   logic [NREQ*DW-1:0]   req_divisor;
   logic [DW-1:0]        div_dividend;
   logic [DW-1:0]        div_divisor;
   logic [DW-1:0]        div_quotient;
   logic                 rsp_valid;
   logic [NREQ-1:0]      rsp_id;
   logic [DW-1:0]        rsp_quot;
   logic                 rsp_dz;
   logic                 busy;

   modport slave (
      input  en, req_valid, req_dividend, req_divisor, div_quotient,
      output req_ready, div_dividend, div_divisor,
      output rsp_valid, rsp_id, rsp_quot, rsp_dz, busy
   );

   modport master (
      output en, req_valid, req_dividend, req_divisor, div_quotient,
      input  req_ready, div_dividend, div_divisor,
      input  rsp_valid, rsp_id, rsp_quot, rsp_dz, busy
   );
endinterface

// File: rtl/div_share_arb.sv
// ----------------------------------------------------------------------------
// div_share_arb
// Shares one pipelined DW-bit integer divider (DIV_LAT cycles) between NREQ
// requesters. One op per cycle is granted round-robin, tagged with its owner
// and a divide-by-zero flag, and its quotient is returned DIV_LAT+1 cycles
// after the handshake on a single response bus, in issue order.
// A zero divisor is replaced by 1 on the divider side; the response then
// carries an all-ones quotient and rsp_dz=1.
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset (discards all in-flight ops)
//   bus    div_share_arb_if.slave: request, divider and response signals
// Interface parameters NREQ/DW must match the module parameters.
// ----------------------------------------------------------------------------
module div_share_arb #(
   parameter int NREQ    = 3,
   parameter int DW      = 18,
   parameter int DIV_LAT = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   div_share_arb_if.slave    bus
);

   localparam int PW  = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int PW1 = PW + 1;
   localparam logic [PW1-1:0]  NREQ_W = PW1'(NREQ);
   localparam logic [NREQ-1:0] ONE_W  = NREQ'(1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   // (base + off) mod NREQ, both operands already below NREQ
   function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base,
                                              input logic [PW-1:0] off);
      logic [PW1-1:0] sum;
      sum = {1'b0, base} + {1'b0, off};
      if (sum >= NREQ_W) begin
         sum = sum - NREQ_W;
      end else begin
         sum = sum;
      end
      return sum[PW-1:0];
   endfunction

   state_t          state_r;
   state_t          state_s;
   logic [PW-1:0]   ptr_r;

   logic [DW-1:0]   dvd_s [NREQ];
   logic [DW-1:0]   dvs_s [NREQ];
   logic [PW-1:0]   grant_idx_s;
   logic [PW-1:0]   cand_s;
   logic            found_s;
   logic            grant_ok_s;
   logic            hs_s;
   logic [NREQ-1:0] ready_s;
   logic [DW-1:0]   sel_dvd_s;
   logic [DW-1:0]   sel_dvs_s;
   logic            sel_dz_s;
   logic            pipe_busy_s;
   logic            pipe_busy_nxt_s;

   logic            tag_v_r  [0:DIV_LAT];
   logic [NREQ-1:0] tag_id_r [0:DIV_LAT];
   logic            tag_dz_r [0:DIV_LAT];

   logic [DW-1:0]   div_dvd_r;
   logic [DW-1:0]   div_dvs_r;
   logic            rsp_valid_r;
   logic [NREQ-1:0] rsp_id_r;
   logic [DW-1:0]   rsp_quot_r;
   logic            rsp_dz_r;
   logic            busy_r;

   for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign dvd_s[gi] = bus.req_dividend[gi*DW +: DW];
      assign dvs_s[gi] = bus.req_divisor[gi*DW +: DW];
   end

   // Round-robin search: first valid requester at or after the pointer, wrapping
   always_comb begin
      grant_idx_s = '0;
      cand_s      = '0;
      found_s     = 1'b0;
      for (int off = 0; off < NREQ; off++) begin
         cand_s = wrap_add(ptr_r, PW'(off));
         if (!found_s && bus.req_valid[cand_s]) begin
            found_s     = 1'b1;
            grant_idx_s = cand_s;
         end else begin
            found_s     = found_s;
            grant_idx_s = grant_idx_s;
         end
      end
   end

   // Grant gating and operand selection; DRAIN and en=0 block new grants
   always_comb begin
      grant_ok_s = bus.en && (state_r != ST_DRAIN);
      hs_s       = grant_ok_s && found_s;
      if (hs_s) begin
         ready_s = ONE_W << grant_idx_s;
      end else begin
         ready_s = '0;
      end
      sel_dvd_s = dvd_s[grant_idx_s];
      sel_dvs_s = dvs_s[grant_idx_s];
      sel_dz_s  = (sel_dvs_s == {DW{1'b0}});
   end

   assign bus.req_ready = ready_s;

   // Occupancy of the tag pipe now, and as it will be after the coming edge
   always_comb begin
      pipe_busy_s     = 1'b0;
      pipe_busy_nxt_s = hs_s;
      for (int i = 0; i <= DIV_LAT; i++) begin
         pipe_busy_s = pipe_busy_s | tag_v_r[i];
      end
      // the last stage leaves the pipe at the coming edge
      for (int i = 0; i < DIV_LAT; i++) begin
         pipe_busy_nxt_s = pipe_busy_nxt_s | tag_v_r[i];
      end
   end

   // FSM next-state: IDLE grants on the same cycle it moves to RUN
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (bus.en && (bus.req_valid != '0)) begin
               state_s = ST_RUN;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (!bus.en) begin
               state_s = pipe_busy_s ? ST_DRAIN : ST_IDLE;
            end else begin
               state_s = ST_RUN;
            end
         end
         ST_DRAIN: begin
            // en is deliberately ignored until the pipe is empty
            if (!pipe_busy_s) begin
               state_s = ST_IDLE;
            end else begin
               state_s = ST_DRAIN;
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Round-robin pointer: moves past the winner, holds when nothing is granted
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_r <= '0;
      end else if (hs_s) begin
         ptr_r <= wrap_add(grant_idx_s, PW'(1));
      end else begin
         ptr_r <= ptr_r;
      end
   end

   // Divider operand registers; a zero divisor is replaced so the divider never sees 0
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_dvd_r <= '0;
         div_dvs_r <= '0;
      end else if (hs_s) begin
         div_dvd_r <= sel_dvd_s;
         div_dvs_r <= sel_dz_s ? DW'(1) : sel_dvs_s;
      end else begin
         div_dvd_r <= div_dvd_r;
         div_dvs_r <= div_dvs_r;
      end
   end

   // Tag pipe: one stage per cycle, stage DIV_LAT lines up with div_quotient
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i <= DIV_LAT; i++) begin
            tag_v_r[i]  <= 1'b0;
            tag_id_r[i] <= '0;
            tag_dz_r[i] <= 1'b0;
         end
      end else begin
         tag_v_r[0]  <= hs_s;
         tag_id_r[0] <= ready_s;
         tag_dz_r[0] <= hs_s && sel_dz_s;
         for (int i = 1; i <= DIV_LAT; i++) begin
            tag_v_r[i]  <= tag_v_r[i-1];
            tag_id_r[i] <= tag_id_r[i-1];
            tag_dz_r[i] <= tag_dz_r[i-1];
         end
      end
   end

   // Response register: strobe for one cycle, payload holds between responses
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid_r <= 1'b0;
         rsp_id_r    <= '0;
         rsp_quot_r  <= '0;
         rsp_dz_r    <= 1'b0;
      end else if (tag_v_r[DIV_LAT]) begin
         rsp_valid_r <= 1'b1;
         rsp_id_r    <= tag_id_r[DIV_LAT];
         rsp_quot_r  <= tag_dz_r[DIV_LAT] ? {DW{1'b1}} : bus.div_quotient;
         rsp_dz_r    <= tag_dz_r[DIV_LAT];
      end else begin
         rsp_valid_r <= 1'b0;
         rsp_id_r    <= rsp_id_r;
         rsp_quot_r  <= rsp_quot_r;
         rsp_dz_r    <= rsp_dz_r;
      end
   end

   // Busy register, computed from next-cycle occupancy and state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_r <= 1'b0;
      end else begin
         busy_r <= pipe_busy_nxt_s || (state_s != ST_IDLE);
      end
   end

   assign bus.div_dividend = div_dvd_r;
   assign bus.div_divisor  = div_dvs_r;
   assign bus.rsp_valid    = rsp_valid_r;
   assign bus.rsp_id       = rsp_id_r;
   assign bus.rsp_quot     = rsp_quot_r;
   assign bus.rsp_dz       = rsp_dz_r;
   assign bus.busy         = busy_r;

endmodule

// File: tb/tb_div_share_arb.sv
// ----------------------------------------------------------------------------
// tb_div_share_arb
// Directed scenarios followed by randomized traffic. A reference model keeps
// the round-robin pointer as an integer, the in-flight ops as a queue of
// expected responses with their due edge, and the engine mode; every cycle
// the grant, divider operands, response bus and busy are compared to it.
// ----------------------------------------------------------------------------
module tb_div_share_arb;
   localparam int NREQ = 3;
   localparam int DW   = 18;
   localparam int LAT  = 3;
   localparam int M_IDLE  = 0;
   localparam int M_RUN   = 1;
   localparam int M_DRAIN = 2;

   typedef struct {
      int            id;
      logic [DW-1:0] quot;
      logic          dz;
      int            due;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   int   checks = 0;
   int   errors = 0;

   exp_t            expq[$];
   int              ptr_m  = 0;
   int              mode_m = M_IDLE;
   int              edge_n = 0;
   logic [DW-1:0]   exp_dvd, exp_dvs, last_quot;
   logic [NREQ-1:0] last_id;
   logic            last_dz;
   logic [DW-1:0]   dq [LAT];

   always #5 clk = ~clk;

   div_share_arb_if #(.NREQ(NREQ), .DW(DW)) bus ();

   div_share_arb #(.NREQ(NREQ), .DW(DW), .DIV_LAT(LAT)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Divider stand-in: operands set at edge k give a quotient valid after edge k+LAT
   always @(posedge clk) begin
      dq[0] <= (bus.div_divisor == '0) ? '1 : bus.div_dividend / bus.div_divisor;
      for (int i = 1; i < LAT; i++) dq[i] <= dq[i-1];
   end
   assign bus.div_quotient = dq[LAT-1];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int pick(input logic [NREQ-1:0] v, input int p);
      for (int o = 0; o < NREQ; o++) begin
         if (((v >> ((p + o) % NREQ)) & NREQ'(1)) != '0) return (p + o) % NREQ;
      end
      return -1;
   endfunction

   task automatic set_req(input int i, input logic v, input logic [DW-1:0] a, input logic [DW-1:0] b);
      if (v) bus.req_valid = bus.req_valid | (NREQ'(1) << i);
      else   bus.req_valid = bus.req_valid & ~(NREQ'(1) << i);
      bus.req_dividend[i*DW +: DW] = a;
      bus.req_divisor[i*DW +: DW]  = b;
   endtask

   // One clock: check grant before the edge, advance model, check registered outputs after it
   task automatic tick();
      int              g;
      logic            en_v;
      logic [NREQ-1:0] vld_v;
      bit              pipe_busy;
      logic [DW-1:0]   a, b;
      exp_t            e;
      @(negedge clk);
      en_v  = bus.en;
      vld_v = bus.req_valid;
      g = (en_v && mode_m != M_DRAIN) ? pick(vld_v, ptr_m) : -1;
      check("req_ready", 64'(bus.req_ready), (g < 0) ? 64'd0 : (64'd1 << g));
      pipe_busy = (expq.size() != 0);
      a = '0;
      b = '0;
      if (g >= 0) begin
         a = bus.req_dividend[g*DW +: DW];
         b = bus.req_divisor[g*DW +: DW];
      end
      @(posedge clk);
      edge_n++;
      case (mode_m)
         M_IDLE:  if (en_v && vld_v != '0) mode_m = M_RUN;
         M_RUN:   if (!en_v) mode_m = pipe_busy ? M_DRAIN : M_IDLE;
         M_DRAIN: if (!pipe_busy) mode_m = M_IDLE;
         default: mode_m = M_IDLE;
      endcase
      if (g >= 0) begin
         e.id   = g;
         e.dz   = (b == '0);
         e.quot = e.dz ? '1 : a / b;
         e.due  = edge_n + LAT + 1;
         expq.push_back(e);
         ptr_m   = (g + 1) % NREQ;
         exp_dvd = a;
         exp_dvs = e.dz ? DW'(1) : b;
      end
      #1;
      if (expq.size() != 0 && expq[0].due == edge_n) begin
         e         = expq.pop_front();
         last_id   = NREQ'(1) << e.id;
         last_quot = e.quot;
         last_dz   = e.dz;
         check("rsp_valid", 64'(bus.rsp_valid), 64'd1);
      end else begin
         check("rsp_valid", 64'(bus.rsp_valid), 64'd0);
      end
      check("rsp_id", 64'(bus.rsp_id), 64'(last_id));
      check("rsp_quot", 64'(bus.rsp_quot), 64'(last_quot));
      check("rsp_dz", 64'(bus.rsp_dz), 64'(last_dz));
      check("div_dividend", 64'(bus.div_dividend), 64'(exp_dvd));
      check("div_divisor", 64'(bus.div_divisor), 64'(exp_dvs));
      check("busy", 64'(bus.busy), (expq.size() != 0 || mode_m != M_IDLE) ? 64'd1 : 64'd0);
   endtask

   task automatic do_reset();
      bus.en        = 1'b0;
      bus.req_valid = '0;
      rst_n         = 1'b0;
      #1;
      check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      check("rst_rsp_id", 64'(bus.rsp_id), 64'd0);
      check("rst_rsp_quot", 64'(bus.rsp_quot), 64'd0);
      check("rst_rsp_dz", 64'(bus.rsp_dz), 64'd0);
      check("rst_busy", 64'(bus.busy), 64'd0);
      check("rst_div_dividend", 64'(bus.div_dividend), 64'd0);
      check("rst_div_divisor", 64'(bus.div_divisor), 64'd0);
      expq.delete();
      ptr_m     = 0;
      mode_m    = M_IDLE;
      exp_dvd   = '0;
      exp_dvs   = '0;
      last_quot = '0;
      last_id   = '0;
      last_dz   = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      bus.en           = 1'b0;
      bus.req_valid    = '0;
      bus.req_dividend = '0;
      bus.req_divisor  = '0;
      #2;
      do_reset();

      // Single op from requester 0
      bus.en = 1'b1;
      set_req(0, 1'b1, 18'd100000, 18'd10);
      tick();
      set_req(0, 1'b0, 18'd0, 18'd0);
      repeat (4) tick();
      check("t1_rsp_valid", 64'(bus.rsp_valid), 64'd1);
      check("t1_rsp_id", 64'(bus.rsp_id), 64'h1);
      check("t1_rsp_quot", 64'(bus.rsp_quot), 64'd10000);
      check("t1_rsp_dz", 64'(bus.rsp_dz), 64'd0);

      // Divide by zero from requester 1
      set_req(1, 1'b1, 18'd500, 18'd0);
      tick();
      set_req(1, 1'b0, 18'd0, 18'd0);
      check("t3_div_divisor", 64'(bus.div_divisor), 64'd1);
      check("t3_div_dividend", 64'(bus.div_dividend), 64'd500);
      repeat (4) tick();
      check("t3_rsp_id", 64'(bus.rsp_id), 64'h2);
      check("t3_rsp_quot", 64'(bus.rsp_quot), 64'h3FFFF);
      check("t3_rsp_dz", 64'(bus.rsp_dz), 64'd1);

      // Lone requester 2 wins at once, pointer wraps to 0
      do_reset();
      bus.en = 1'b1;
      set_req(2, 1'b1, 18'd900, 18'd3);
      #1;
      check("t6_first_grant", 64'(bus.req_ready), 64'h4);
      tick();
      set_req(0, 1'b1, 18'd77, 18'd7);
      #1;
      check("t6_second_grant", 64'(bus.req_ready), 64'h1);
      tick();
      bus.req_valid = '0;
      repeat (5) tick();

      // All three held valid for six cycles from pointer 0
      do_reset();
      bus.en = 1'b1;
      for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, DW'(1000 * (i + 1)), DW'(i + 2));
      for (int n = 0; n < 6; n++) begin
         #1;
         check("t2_grant", 64'(bus.req_ready), 64'd1 << (n % NREQ));
         tick();
      end
      bus.req_valid = '0;
      repeat (5) tick();

      // en dropped with three ops in flight
      bus.req_valid = '1;
      repeat (3) tick();
      bus.en = 1'b0;
      #1;
      check("t4_ready_blocked", 64'(bus.req_ready), 64'd0);
      repeat (6) tick();
      check("t4_busy_low", 64'(bus.busy), 64'd0);
      bus.req_valid = '0;

      // Reset two cycles after an issue discards the op and clears the pointer
      bus.en = 1'b1;
      set_req(0, 1'b1, 18'd1234, 18'd7);
      tick();
      set_req(0, 1'b0, 18'd0, 18'd0);
      repeat (2) tick();
      do_reset();
      bus.en = 1'b1;
      repeat (6) tick();
      set_req(0, 1'b1, 18'd40, 18'd4);
      set_req(1, 1'b1, 18'd41, 18'd4);
      #1;
      check("t5_pointer_zero", 64'(bus.req_ready), 64'h1);
      tick();
      bus.req_valid = '0;
      repeat (5) tick();

      // Randomized traffic with occasional en toggles and zero divisors
      do_reset();
      bus.en = 1'b1;
      for (int n = 0; n < 1500; n++) begin
         if ($urandom_range(0, 19) == 0) bus.en = ~bus.en;
         for (int i = 0; i < NREQ; i++) begin
            logic [DW-1:0] a, b;
            a = DW'($urandom);
            case ($urandom_range(0, 3))
               0:       b = '0;
               1:       b = DW'($urandom_range(1, 15));
               default: b = DW'($urandom);
            endcase
            set_req(i, 1'($urandom_range(0, 1)), a, b);
         end
         tick();
      end
      bus.en        = 1'b0;
      bus.req_valid = '0;
      repeat (10) tick();
      check("final_busy_low", 64'(bus.busy), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
